// File: rtl/fft_input_stage_if.sv
// Serial complex sample bus feeding the FFT input stage.
// Source drives one sample per qualified cycle; there is no backpressure.
interface fft_input_stage_if #(
  parameter int WIDTH = 9
);
  logic                    in_valid;
  logic                    in_sof;
  logic signed [WIDTH-1:0] in_re;
  logic signed [WIDTH-1:0] in_im;

  modport master (
    output in_valid,
    output in_sof,
    output in_re,
    output in_im
  );

  modport slave (
    input in_valid,
    input in_sof,
    input in_re,
    input in_im
  );
endinterface

// File: rtl/fft_input_stage.sv
// First stage of a 32-point FFT: buffers x[0..15] and pairs each with x[k+16].
// Emits registered butterfly operands, twiddle address and commutator flags.
module fft_input_stage #(
  parameter int WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  fft_input_stage_if.slave        s,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] state1_inUI_re,
  output logic signed [WIDTH-1:0] state1_inUI_im,
  output logic signed [WIDTH-1:0] state1_inLI_re,
  output logic signed [WIDTH-1:0] state1_inLI_im,
  output logic [3:0]              rom_16_counter,
  output logic                    state1_com1_flag,
  output logic                    state2_com1_flag,
  output logic                    state2_com2_flag,
  output logic                    state3_com1_flag,
  output logic                    state3_com2_flag,
  output logic                    state3_com3_flag,
  output logic                    sof_err
);

  logic [4:0] idx;
  logic [4:0] cur_idx;
  logic [3:0] k;
  logic       accept;
  logic       second;

  logic signed [WIDTH-1:0] mem_re [16];
  logic signed [WIDTH-1:0] mem_im [16];

  // in_sof restarts the frame on the very sample that carries it
  assign accept  = s.in_valid;
  assign cur_idx = s.in_sof ? 5'd0 : idx;
  assign second  = cur_idx[4];
  assign k       = cur_idx[3:0];

  always_ff @(posedge clk) begin
    if (accept && !second) begin
      mem_re[k] <= s.in_re;
      mem_im[k] <= s.in_im;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx              <= '0;
      out_valid        <= 1'b0;
      sof_err          <= 1'b0;
      state1_inUI_re   <= '0;
      state1_inUI_im   <= '0;
      state1_inLI_re   <= '0;
      state1_inLI_im   <= '0;
      rom_16_counter   <= '0;
      state1_com1_flag <= 1'b0;
      state2_com1_flag <= 1'b0;
      state2_com2_flag <= 1'b0;
      state3_com1_flag <= 1'b0;
      state3_com2_flag <= 1'b0;
      state3_com3_flag <= 1'b0;
    end else begin
      out_valid <= accept && second;
      sof_err   <= accept && s.in_sof && (idx != 5'd0);
      if (accept) begin
        idx <= cur_idx + 5'd1;
      end
      if (accept && second) begin
        state1_inUI_re   <= mem_re[k];
        state1_inUI_im   <= mem_im[k];
        state1_inLI_re   <= s.in_re;
        state1_inLI_im   <= s.in_im;
        rom_16_counter   <= k;
        state1_com1_flag <= 1'b1;
        state2_com1_flag <= k[3];
        state2_com2_flag <= ~k[3];
        state3_com1_flag <= k[2];
        state3_com2_flag <= k[3] ^ k[2];
        state3_com3_flag <= k[1];
      end
    end
  end

endmodule

// File: tb/tb_fft_input_stage.sv
// Scoreboard bench for fft_input_stage: expected pairs queued at drive
// time, popped and compared when out_valid is seen.
module tb_fft_input_stage;

  localparam int W = 9;

  typedef struct {
    int              cyc;
    logic signed [W-1:0] ui_re;
    logic signed [W-1:0] ui_im;
    logic signed [W-1:0] li_re;
    logic signed [W-1:0] li_im;
    logic [3:0]      k;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  logic out_valid;
  logic signed [W-1:0] ui_re, ui_im, li_re, li_im;
  logic [3:0] rom;
  logic s1c1, s2c1, s2c2, s3c1, s3c2, s3c3;
  logic sof_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int err_cnt = 0;
  int pair_cnt = 0;
  exp_t q[$];
  exp_t e;
  logic [5:0] seen_f [16];
  logic [45:0] last_o;
  logic [45:0] cur_o;
  logic [5:0] cur_f;
  logic [5:0] exp_f;

  fft_input_stage_if #(.WIDTH(W)) bus ();

  fft_input_stage #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .s                (bus),
    .out_valid        (out_valid),
    .state1_inUI_re   (ui_re),
    .state1_inUI_im   (ui_im),
    .state1_inLI_re   (li_re),
    .state1_inLI_im   (li_im),
    .rom_16_counter   (rom),
    .state1_com1_flag (s1c1),
    .state2_com1_flag (s2c1),
    .state2_com2_flag (s2c2),
    .state3_com1_flag (s3c1),
    .state3_com2_flag (s3c2),
    .state3_com3_flag (s3c3),
    .sof_err          (sof_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    cur_f = {s1c1, s2c1, s2c2, s3c1, s3c2, s3c3};
    cur_o = {ui_re, ui_im, li_re, li_im, rom, cur_f};
    if (rst) begin
      last_o = '0;
    end else begin
      if (sof_err) err_cnt++;
      if (out_valid) begin
        pair_cnt++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL spurious_valid cyc=%0d k=%0d", cyc, rom);
        end else begin
          e = q.pop_front();
          if ({ui_re, ui_im, li_re, li_im, rom} !==
              {e.ui_re, e.ui_im, e.li_re, e.li_im, e.k} ||
              cyc != e.cyc) begin
            bad++;
            $display("FAIL pair cyc=%0d got ui=(%0d,%0d) li=(%0d,%0d) k=%0d want cyc=%0d ui=(%0d,%0d) li=(%0d,%0d) k=%0d",
                     cyc, ui_re, ui_im, li_re, li_im, rom,
                     e.cyc, e.ui_re, e.ui_im, e.li_re, e.li_im, e.k);
          end
          exp_f = {1'b1, e.k[3], ~e.k[3], e.k[2], e.k[3] ^ e.k[2], e.k[1]};
          total++;
          if (cur_f !== exp_f) begin
            bad++;
            $display("FAIL flags k=%0d got %b want %b", e.k, cur_f, exp_f);
          end
          seen_f[e.k] = cur_f;
        end
      end else begin
        total++;
        if (cur_o !== last_o) begin
          bad++;
          $display("FAIL hold cyc=%0d got %h want %h", cyc, cur_o, last_o);
        end
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          total++;
          bad++;
          $display("FAIL missing_pair cyc=%0d got out_valid=0 want k=%0d", cyc, e.k);
        end
      end
      last_o = cur_o;
    end
  end

  task automatic send(input logic v, input logic sof, input int re, input int im);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_re    = W'(re);
    bus.in_im    = W'(im);
  endtask

  task automatic idle();
    send(1'b0, 1'($urandom_range(0, 1)), int'($urandom), int'($urandom));
  endtask

  task automatic send_frame(input int base, input bit use_sof, input bit gapped,
                            input int count, input bit rnd);
    int re [32];
    int im [32];
    exp_t x;
    for (int n = 0; n < count; n++) begin
      re[n] = rnd ? int'($urandom_range(0, 511)) - 256 : base + n;
      im[n] = rnd ? int'($urandom_range(0, 511)) - 256 : -(base + n);
      send(1'b1, use_sof && n == 0, re[n], im[n]);
      if (n >= 16) begin
        x.cyc   = cyc + 1;
        x.ui_re = W'(re[n-16]);
        x.ui_im = W'(im[n-16]);
        x.li_re = W'(re[n]);
        x.li_im = W'(im[n]);
        x.k     = 4'(n - 16);
        q.push_back(x);
      end
      if (gapped) idle();
    end
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (q.size() > 0 && n < 8) begin
      idle();
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    total++;
    if ({out_valid, sof_err, ui_re, ui_im, li_re, li_im, rom,
         s1c1, s2c1, s2c2, s3c1, s3c2, s3c3} !== '0) begin
      bad++;
      $display("FAIL %s got v=%b err=%b ui=(%0d,%0d) li=(%0d,%0d) k=%0d want all zero",
               tag, out_valid, sof_err, ui_re, ui_im, li_re, li_im, rom);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 0;
    bus.in_sof   = 0;
    bus.in_re    = '0;
    bus.in_im    = '0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset_state");
    @(posedge clk);
    #1;
    rst = 0;
    // first frame after reset carries no in_sof
    send_frame(0, 1'b0, 1'b0, 32, 1'b1);
    drain();
  endtask

  task automatic test_continuous();
    int p0 = pair_cnt;
    for (int i = 0; i < 16; i++) seen_f[i] = '0;
    send_frame(0, 1'b1, 1'b0, 32, 1'b0);
    drain();
    total++;
    if (pair_cnt - p0 != 16) begin
      bad++;
      $display("FAIL continuous_count got %0d want 16", pair_cnt - p0);
    end
  endtask

  task automatic test_flag_sweep();
    total++;
    if (seen_f[5] !== 6'b101110) begin
      bad++;
      $display("FAIL flags_k5 got %b want 101110", seen_f[5]);
    end
    total++;
    if (seen_f[12] !== 6'b110100) begin
      bad++;
      $display("FAIL flags_k12 got %b want 110100", seen_f[12]);
    end
  endtask

  task automatic test_gapped();
    send_frame(40, 1'b1, 1'b1, 32, 1'b0);
    drain();
    send_frame(0, 1'b1, 1'b1, 32, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    int p0 = pair_cnt;
    int e0 = err_cnt;
    send_frame(0, 1'b1, 1'b0, 32, 1'b1);
    send_frame(0, 1'b1, 1'b0, 32, 1'b1);
    drain();
    total++;
    if (pair_cnt - p0 != 32) begin
      bad++;
      $display("FAIL b2b_count got %0d want 32", pair_cnt - p0);
    end
    total++;
    if (err_cnt != e0) begin
      bad++;
      $display("FAIL b2b_sof_err got %0d want 0", err_cnt - e0);
    end
  endtask

  task automatic test_truncation();
    int p0 = pair_cnt;
    int e0 = err_cnt;
    send_frame(0, 1'b1, 1'b0, 20, 1'b1);
    send_frame(0, 1'b1, 1'b0, 32, 1'b1);
    drain();
    total++;
    if (err_cnt - e0 != 1) begin
      bad++;
      $display("FAIL trunc_sof_err got %0d pulses want 1", err_cnt - e0);
    end
    total++;
    if (pair_cnt - p0 != 20) begin
      bad++;
      $display("FAIL trunc_count got %0d want 20", pair_cnt - p0);
    end
  endtask

  task automatic test_mid_reset();
    send_frame(0, 1'b1, 1'b0, 11, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    rst = 1;
    #2;
    check_zero("mid_reset_state");
    @(posedge clk);
    #1;
    rst = 0;
    send_frame(0, 1'b0, 1'b0, 32, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_flag_sweep();
    test_gapped();
    test_back_to_back();
    test_truncation();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
